// File: rtl/video_shifter.sv
// -----------------------------------------------------------------------------
// video_shifter
//
// Pixel serializer at the end of the video fetch path. The 16-bit framebuffer
// words returned by the fetch slots go into a small word FIFO. Each line they
// are shifted out MSB-first, one pixel per pixel tick, as a registered
// monochrome pixel plus an active flag for the scan-out stage.
//
// Parameters
//   FIFO_DEPTH  : word FIFO entries (power of two, 2..16)
//   START_FILL  : words that must be queued before a line may start
//   LINE_PIXELS : pixels shifted per line (multiple of 16, <= 1008)
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   pixEn      in   one-clk pixel tick
//   _hblank    in   active-low horizontal blank
//   _vblank    in   active-low vertical blank
//   wordValid  in   wordData valid this clk
//   wordData   in   framebuffer word, bit 15 = leftmost pixel
//   wordReady  out  FIFO not full; a push happens on wordValid & wordReady
//   pixel      out  current pixel, 1 = black
//   active     out  pixel is a valid shifted pixel
//   underflow  out  sticky: a word was needed while the FIFO was empty
// -----------------------------------------------------------------------------
module video_shifter #(
   parameter int FIFO_DEPTH  = 4,
   parameter int START_FILL  = 1,
   parameter int LINE_PIXELS = 512
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pixEn,
   input  logic        _hblank,
   input  logic        _vblank,
   input  logic        wordValid,
   input  logic [15:0] wordData,
   output logic        wordReady,
   output logic        pixel,
   output logic        active,
   output logic        underflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] START_C = CW'(START_FILL);
   localparam logic [9:0]    LINE_C  = 10'(LINE_PIXELS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      SHIFT = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [15:0]     shift_q, shift_d;
   logic [3:0]      bit_q,   bit_d;     // index of the next bit to emit
   logic [9:0]      pcnt_q,  pcnt_d;    // pixels emitted so far this line
   logic            pix_q,   pix_d;
   logic            act_q,   act_d;
   logic            unf_q,   unf_d;
   logic            de_q;               // de as sampled on the previous tick

   logic [15:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_q, wr_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            de;
   logic            de_rise;
   logic            push;
   logic            pop;
   logic            flush;
   logic [15:0]     head;

   assign de        = _hblank & _vblank;
   assign de_rise   = pixEn & de & ~de_q;
   assign wordReady = (cnt_q < DEPTH_C);
   assign push      = wordValid & wordReady;
   assign head      = mem_q[rd_q];

   assign pixel     = pix_q;
   assign active    = act_q;
   assign underflow = unf_q;

   // ---------------------------------------------------------------------------
   // Line state machine: next state, shifter and output pixel
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      pcnt_d  = pcnt_q;
      pix_d   = pix_q;
      act_d   = act_q;
      unf_d   = unf_q;
      pop     = 1'b0;
      flush   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (de_rise) state_d = ARMED;
         end

         ARMED: begin
            if (pixEn) begin
               if (cnt_q >= START_C) begin
                  // first pixel of the line is bit 15 of the head word
                  pop     = 1'b1;
                  shift_d = head;
                  pix_d   = head[15];
                  act_d   = 1'b1;
                  bit_d   = 4'd14;
                  pcnt_d  = 10'd1;
                  state_d = SHIFT;
               end else if (!de) begin
                  // display window closed before enough data arrived
                  unf_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end

         SHIFT: begin
            if (pixEn) begin
               if (pcnt_q == LINE_C) begin
                  // tick after the last pixel: blank and drop any leftovers
                  pix_d   = 1'b0;
                  act_d   = 1'b0;
                  flush   = 1'b1;
                  bit_d   = 4'd0;
                  pcnt_d  = 10'd0;
                  state_d = IDLE;
               end else begin
                  pcnt_d = pcnt_q + 10'd1;
                  if (bit_q == 4'd15) begin
                     // previous tick emitted bit 0: start a fresh word
                     if (cnt_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        pix_d   = head[15];
                     end else begin
                        // starved: show 16 white pixels, keep line timing
                        unf_d   = 1'b1;
                        shift_d = 16'h0000;
                        pix_d   = 1'b0;
                     end
                     bit_d = 4'd14;
                  end else begin
                     pix_d = shift_q[bit_q];
                     bit_d = bit_q - 4'd1;  // 0 wraps to 15, which requests a word
                  end
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FIFO pointers and occupancy. Flush wins over a same-clk push, so a word
   // accepted in the flush clk is discarded.
   // ---------------------------------------------------------------------------
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wr_d = wr_q + AW'(1);
         if (pop)  rd_d = rd_q + AW'(1);
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= wordData;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= 16'h0000;
         bit_q   <= 4'd0;
         pcnt_q  <= 10'd0;
         pix_q   <= 1'b0;
         act_q   <= 1'b0;
         unf_q   <= 1'b0;
         de_q    <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         pcnt_q  <= pcnt_d;
         pix_q   <= pix_d;
         act_q   <= act_d;
         unf_q   <= unf_d;
         if (pixEn) de_q <= de;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_video_shifter.sv
module tb_video_shifter;

   localparam int LP = 512;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pe  = 1'b0;
   logic        de  = 1'b0;
   logic        wv  = 1'b0;
   logic [15:0] wd  = 16'h0000;
   logic        rdy, pix, act, unf;

   int checks   = 0;
   int failures = 0;

   logic [15:0] lw [32];

   always #5 clk = ~clk;

   video_shifter #(.FIFO_DEPTH(4), .START_FILL(1), .LINE_PIXELS(LP)) dut (
      .clk       (clk),
      .reset     (rst),
      .pixEn     (pe),
      ._hblank   (de),
      ._vblank   (1'b1),
      .wordValid (wv),
      .wordData  (wd),
      .wordReady (rdy),
      .pixel     (pix),
      .active    (act),
      .underflow (unf)
   );

   typedef struct {
      logic        rst;
      logic        pe;
      logic        de;
      logic        wv;
      logic [15:0] wd;
      logic [3:0]  exp;   // {pixel, active, underflow, wordReady}
      string       nm;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic p, input logic d, input logic v,
                      input logic [15:0] w, input logic [3:0] e, input string nm);
      vec_t x;
      x.rst = r; x.pe = p; x.de = d; x.wv = v; x.wd = w; x.exp = e; x.nm = nm;
      tbl.push_back(x);
   endtask

   // one pixel tick: a pe=1 clk (optionally pushing) then a pe=0 clk
   task automatic do_tick(input logic push, input logic [15:0] w,
                          output logic p, output logic a);
      pe = 1'b1; wv = push; wd = w;
      @(negedge clk);
      p = pix; a = act;
      pe = 1'b0; wv = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset(input string nm);
      rst = 1'b1; pe = 1'b0; wv = 1'b0; de = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk({nm, "_pixel"}, pix, 0);
      chk({nm, "_active"}, act, 0);
      chk({nm, "_underflow"}, unf, 0);
      chk({nm, "_ready"}, rdy, 1);
      chk({nm, "_count"}, dut.cnt_q, 0);
   endtask

   // Runs one line using lw[0..nw-1]: lw[0] is prefetched in IDLE, word j is
   // pushed at tick 16*j-14. abort_at>0 resets the DUT right after that tick.
   task automatic run_line(input int nw, input int abort_at, input string nm);
      logic p, a, e, psh;
      int   act_cnt, errs, k, j;
      de = 1'b0;
      do_tick(1'b0, 16'h0, p, a);
      wv = 1'b1; wd = lw[0]; pe = 1'b0;
      @(negedge clk);
      wv = 1'b0;
      de = 1'b1;
      do_tick(1'b0, 16'h0, p, a);
      chk({nm, "_armed_active"}, a, 0);
      act_cnt = 0;
      errs    = 0;
      for (int t = 1; t <= LP; t++) begin
         j   = (t + 14) / 16;
         psh = ((t + 14) % 16 == 0) && (j < nw);
         do_tick(psh, lw[j % 32], p, a);
         k = (t - 1) / 16;
         e = (k < nw) ? lw[k][15 - ((t - 1) % 16)] : 1'b0;
         if (a) act_cnt++;
         if (p !== e || a !== 1'b1) errs++;
         if (t == abort_at) begin
            chk({nm, "_pix_errs_before_reset"}, errs, 0);
            rst = 1'b1;
            @(negedge clk);
            chk({nm, "_rst_active"}, act, 0);
            chk({nm, "_rst_pixel"}, pix, 0);
            chk({nm, "_rst_count"}, dut.cnt_q, 0);
            chk({nm, "_rst_underflow"}, unf, 0);
            rst = 1'b0;
            return;
         end
      end
      chk({nm, "_pix_errs"}, errs, 0);
      chk({nm, "_active_ticks"}, act_cnt, LP);
      do_tick(1'b0, 16'h0, p, a);
      chk({nm, "_end_active"}, a, 0);
      chk({nm, "_end_pixel"}, p, 0);
      chk({nm, "_end_count"}, dut.cnt_q, 0);
   endtask

   initial begin
      logic        p, a;
      logic        bits [16];
      logic [15:0] fq [6];
      int          errs;

      // ---- table: reset, single word 0xA5F0, then starvation on tick 17 ----
      bits = '{1,0,1,0, 0,1,0,1, 1,1,1,1, 0,0,0,0};
      add(1, 0, 0, 0, 16'h0000, 4'b0001, "reset0");
      add(1, 0, 0, 0, 16'h0000, 4'b0001, "reset1");
      add(0, 1, 0, 1, 16'hA5F0, 4'b0001, "push_idle");
      add(0, 0, 1, 0, 16'h0000, 4'b0001, "idle_hold");
      add(0, 1, 1, 0, 16'h0000, 4'b0001, "de_rise");
      add(0, 0, 1, 0, 16'h0000, 4'b0001, "armed");
      for (int i = 0; i < 16; i++) begin
         add(0, 1, 1, 0, 16'h0000, {bits[i], 3'b101}, "bit");
         add(0, 0, 1, 0, 16'h0000, {bits[i], 3'b101}, "bit_hold");
      end
      add(0, 1, 1, 0, 16'h0000, 4'b0111, "starved");

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; pe = tbl[i].pe; de = tbl[i].de;
         wv  = tbl[i].wv;  wd = tbl[i].wd;
         @(negedge clk);
         chk($sformatf("%s[%0d]", tbl[i].nm, i), {pix, act, unf, rdy}, tbl[i].exp);
      end
      pe = 1'b0; wv = 1'b0;

      // ---- full line of alternating black/white words ----
      do_reset("reset_a");
      for (int i = 0; i < 32; i++) lw[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      run_line(32, 0, "full");
      chk("full_underflow", unf, 0);

      // ---- starved line, then a good line with underflow still sticky ----
      run_line(2, 0, "short");
      chk("short_underflow", unf, 1);
      run_line(32, 0, "after_short");
      chk("after_short_underflow", unf, 1);

      // ---- FIFO full in IDLE, push+pop in the same clk while shifting ----
      do_reset("reset_b");
      fq = '{16'hF00F, 16'h0FF0, 16'hAAAA, 16'h3C3C, 16'h5A5A, 16'h8001};
      do_tick(1'b0, 16'h0, p, a);
      for (int i = 0; i < 4; i++) begin
         wv = 1'b1; wd = fq[i];
         @(negedge clk);
         chk($sformatf("fill_ready[%0d]", i), rdy, (i < 3) ? 1 : 0);
      end
      wv = 1'b1; wd = 16'h1234;           // offered while full: must be dropped
      @(negedge clk);
      chk("full_ready_held", rdy, 0);
      wv = 1'b0;
      de = 1'b1;
      do_tick(1'b0, 16'h0, p, a);
      errs = 0;
      for (int t = 1; t <= 96; t++) begin
         do_tick(t == 17, fq[4], p, a);
         if (p !== fq[(t - 1) / 16][15 - ((t - 1) % 16)] || a !== 1'b1) errs++;
         if (t == 1)  chk("ready_after_first_pop", rdy, 1);
         if (t == 17) begin
            chk("ready_after_push_pop", rdy, 1);
            wv = 1'b1; wd = fq[5];        // fills the last slot: 3 -> 4
            @(negedge clk);
            wv = 1'b0;
            chk("ready_after_refill", rdy, 0);
         end
      end
      chk("fifo_order_errs", errs, 0);
      chk("fifo_underflow", unf, 0);

      // ---- reset at pixel 200, then a clean one-word line ----
      do_reset("reset_c");
      for (int i = 0; i < 32; i++) lw[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      run_line(32, 200, "abort");
      lw[0] = 16'h8001;
      run_line(1, 0, "restart");
      chk("restart_underflow", unf, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/video_shifter.md
# video_shifter

Pixel serializer at the consuming end of the Mac Plus video fetch path: accepts the 16-bit framebuffer words that the video timer's fetch slots return from memory, buffers them in a small FIFO, and shifts them out MSB-first at one pixel per pixel tick. It outputs a registered monochrome pixel and an active flag for the scan-out/DAC stage.

## Interface
Parameters:
- FIFO_DEPTH, 4, word FIFO entries; power of two, 2..16
- START_FILL, 1, words required in the FIFO before a line may start shifting; 1..FIFO_DEPTH
- LINE_PIXELS, 512, pixels shifted per line; multiple of 16, max 1008

Ports:
- clk  in  1  system clock (32.5 MHz domain)
- reset  in  1  synchronous, active-high
- pixEn  in  1  pixel tick, one clk wide (clk8_en_n | clk8_en_p)
- _hblank  in  1  active-low horizontal blank
- _vblank  in  1  active-low vertical blank
- wordValid  in  1  wordData valid this clk
- wordData  in  16  framebuffer word, bit 15 = leftmost pixel
- wordReady  out  1  FIFO not full; push occurs when wordValid & wordReady
- pixel  out  1  current pixel, 1 = black
- active  out  1  pixel is a valid shifted pixel
- underflow  out  1  sticky: a word was needed and the FIFO was empty

## Operation
- de = _hblank & _vblank, sampled only on pixEn ticks; deRise = de high and previous sampled de low.
- FIFO: FIFO_DEPTH x 16, count width log2(FIFO_DEPTH)+1. Push and pop in the same clk are both honoured (count unchanged). Pushes accepted in every state, including IDLE (prefetch).
- States:
  - IDLE: active=0, pixel=0. deRise -> ARMED.
  - ARMED: active=0. On pixEn with count >= START_FILL: pop head into shifter, output bit 15, active=1, bitIdx=14, pixCnt=1 -> SHIFT. On pixEn with de sampled low: set underflow -> IDLE.
  - SHIFT: on each pixEn output shifter[bitIdx], decrement bitIdx, pixCnt++. When a new word is needed (previous tick emitted bit 0): pop if count>0, else set underflow and substitute 0x0000 for that 16-pixel word (no pop). When pixCnt reaches LINE_PIXELS on a tick, that tick is the last pixel; the following pixEn drives active=0, pixel=0, flushes FIFO (count=0) -> IDLE.
- Flush beats a simultaneous push: word offered in the flush clk is accepted (wordReady high) and discarded.
- deRise while in ARMED or SHIFT is ignored; lines are timed by LINE_PIXELS, not by _hblank.
- underflow clears only on reset.
- reset (any state, mid-line included): state IDLE, FIFO empty, shifter 0, counters 0.

## Timing
- Reset values: pixel=0, active=0, underflow=0, wordReady=1.
- pixel/active are registered; they change only on the clk after a clk with pixEn=1 and hold between ticks.
- Word pushed at clk N is poppable at clk N+1 (count visible next clk).
- First pixel of a line: earliest at the first pixEn after deRise for which count >= START_FILL; pixel valid on the following clk.
- wordReady = (count < FIFO_DEPTH), combinational from registered count; a pop in the same clk does not raise it early.
- pixCnt 10 bits; bitIdx 4 bits, wraps 0 -> 15 with pop.

## Test plan
- Reset: after reset high 2 clks -> pixel=0, active=0, underflow=0, wordReady=1, count 0.
- Single word: push 0xA5F0 in IDLE, raise de, pixEn every 2 clks -> pixel sequence 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0 with active=1 for those 16 ticks.
- Full line: feed 32 words 0xFFFF/0x0000 alternating, one word per 16 ticks -> exactly 512 active ticks, 16 ones then 16 zeros repeating, underflow stays 0, count 0 after flush.
- Underflow: supply only 2 words for a line -> pixels 33..512 are 0, active still 512 ticks, underflow=1 and stays 1 through the next good line.
- FIFO full: push 4 words in IDLE -> wordReady=0, 5th wordValid ignored; in SHIFT push+pop in same clk -> count unchanged, order preserved.
- Reset mid-line at pixel 200 -> next clk active=0, pixel=0, count 0; next deRise with one word starts cleanly at bit 15.
